// File: rtl/weight_loader_pkg.sv
// Shared configuration for the weight loader: default tile geometry, word width
// and the loader FSM state type.
package weight_loader_pkg;

    localparam int sys_cols   = 4;
    localparam int W_BITWIDTH = 8;
    localparam int W_rows     = 3;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LOADED = 2'd1,
        DRAIN  = 2'd2
    } wl_state_t;

endpackage

// File: rtl/weight_loader.sv
// Weight loader: scatters a row-major weight tile across per-column FIFOs, holds
// it until start, then strobes the weight buffer once per tile row.
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int COLS = sys_cols,
    parameter int DW   = W_BITWIDTH,
    parameter int ROWS = W_rows
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [COLS-1:0] col_full,
    output logic [COLS-1:0] wr_en,
    output logic [DW-1:0]   wr_data,
    input  logic            start,
    output logic            read,
    output logic            tile_loaded,
    output logic            done
);

    // A single column still needs a one-bit pointer to stay a legal vector.
    localparam int CPW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RCW = $clog2(ROWS + 1);
    localparam logic [CPW-1:0] COL_LAST = CPW'(COLS - 1);
    localparam logic [RCW-1:0] ROW_LAST = RCW'(ROWS - 1);

    wl_state_t       state_r;
    wl_state_t       state_s;
    logic [CPW-1:0]  col_ptr_r;
    logic [CPW-1:0]  col_ptr_s;
    logic [RCW-1:0]  row_cnt_r;
    logic [RCW-1:0]  row_cnt_s;
    logic [RCW-1:0]  drain_cnt_r;
    logic [RCW-1:0]  drain_cnt_s;
    logic [COLS-1:0] wr_en_r;
    logic [DW-1:0]   wr_data_r;
    logic            done_r;
    logic            done_s;
    logic            in_ready_s;
    logic            fire_s;

    function automatic logic [COLS-1:0] col_onehot(input logic [CPW-1:0] idx);
        logic [COLS-1:0] one;
        one    = '0;
        one[0] = 1'b1;
        return one << idx;
    endfunction

    // Accept only while filling and the addressed column has room; never during reset.
    always_comb begin
        if (!rst && (state_r == FILL) && !col_full[col_ptr_r]) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign fire_s = in_valid & in_ready_s;

    // Next-state and counter update for the fill / hold / drain sequence.
    always_comb begin
        state_s     = state_r;
        col_ptr_s   = col_ptr_r;
        row_cnt_s   = row_cnt_r;
        drain_cnt_s = drain_cnt_r;
        done_s      = 1'b0;
        case (state_r)
            FILL: begin
                if (fire_s) begin
                    if (col_ptr_r == COL_LAST) begin
                        col_ptr_s = '0;
                        if (row_cnt_r == ROW_LAST) begin
                            row_cnt_s = '0;
                            state_s   = LOADED;
                        end else begin
                            row_cnt_s = row_cnt_r + RCW'(1);
                        end
                    end else begin
                        col_ptr_s = col_ptr_r + CPW'(1);
                    end
                end else begin
                    col_ptr_s = col_ptr_r;
                end
            end
            LOADED: begin
                if (start) begin
                    state_s     = DRAIN;
                    drain_cnt_s = '0;
                end else begin
                    state_s = LOADED;
                end
            end
            DRAIN: begin
                if (drain_cnt_r == ROW_LAST) begin
                    drain_cnt_s = '0;
                    state_s     = FILL;
                    done_s      = 1'b1;
                end else begin
                    drain_cnt_s = drain_cnt_r + RCW'(1);
                end
            end
            default: begin
                state_s     = FILL;
                col_ptr_s   = '0;
                row_cnt_s   = '0;
                drain_cnt_s = '0;
            end
        endcase
    end

    // State, counters and the registered FIFO write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= FILL;
            col_ptr_r   <= '0;
            row_cnt_r   <= '0;
            drain_cnt_r <= '0;
            wr_en_r     <= '0;
            wr_data_r   <= '0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            col_ptr_r   <= col_ptr_s;
            row_cnt_r   <= row_cnt_s;
            drain_cnt_r <= drain_cnt_s;
            done_r      <= done_s;
            if (fire_s) begin
                wr_en_r   <= col_onehot(col_ptr_r);
                wr_data_r <= in_data;
            end else begin
                wr_en_r   <= '0;
                wr_data_r <= wr_data_r;
            end
        end
    end

    assign in_ready    = in_ready_s;
    assign wr_en       = wr_en_r;
    assign wr_data     = wr_data_r;
    assign read        = (state_r == DRAIN);
    assign tile_loaded = (state_r == LOADED);
    assign done        = done_r;

endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader (COLS=4, ROWS=3) against a word-count
// reference model of the tile fill / hold / drain behaviour.
module tb_weight_loader;

    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int ROWS = 3;
    localparam int TILE = COLS * ROWS;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [COLS-1:0] col_full;
    logic [COLS-1:0] wr_en;
    logic [DW-1:0]   wr_data;
    logic            start;
    logic            read;
    logic            tile_loaded;
    logic            done;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 = filling, 1 = tile held, 2 = draining.
    int              m_mode  = 0;
    int              m_k     = 0;
    int              m_reads = 0;
    logic            exp_ready;
    logic            exp_read;
    logic            exp_done;
    logic            exp_tile;
    logic [COLS-1:0] exp_wr_en;
    logic [DW-1:0]   exp_wr_data;
    logic            obs_ready;

    weight_loader #(.COLS(COLS), .DW(DW), .ROWS(ROWS)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .col_full    (col_full),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .start       (start),
        .read        (read),
        .tile_loaded (tile_loaded),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic logic model_ready();
        return (!rst && (m_mode == 0) && !col_full[m_k % COLS]);
    endfunction

    task automatic model_clock();
        logic f;
        f         = in_valid && model_ready();
        exp_wr_en = '0;
        exp_done  = 1'b0;
        if (rst) begin
            m_mode      = 0;
            m_k         = 0;
            m_reads     = 0;
            exp_wr_data = '0;
        end else begin
            if (f) begin
                exp_wr_en   = COLS'(1) << (m_k % COLS);
                exp_wr_data = in_data;
                m_k++;
            end
            if (m_mode == 0 && m_k == TILE) begin
                m_mode = 1;
                m_k    = 0;
            end else if (m_mode == 1 && start) begin
                m_mode  = 2;
                m_reads = 0;
            end else if (m_mode == 2) begin
                m_reads++;
                if (m_reads == ROWS) begin
                    m_mode   = 0;
                    exp_done = 1'b1;
                end
            end
        end
        exp_read = (m_mode == 2);
        exp_tile = (m_mode == 1);
    endtask

    // One clock: drive inputs, capture in_ready, advance model, settle past the edge.
    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic [COLS-1:0] cf,
                       input logic s, input logic r);
        in_valid = v;
        in_data  = d;
        col_full = cf;
        start    = s;
        rst      = r;
        #1;
        obs_ready = in_ready;
        exp_ready = model_ready();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_words(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) cyc(1'b1, base + DW'(i), '0, 1'b0, 1'b0);
    endtask

    task automatic run_drain();
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        for (int j = 0; j < ROWS + 1; j++) cyc(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 8'hFF, '0, 1'b1, 1'b1);
            checks++;
            if (obs_ready !== 1'b0) begin
                failures++;
                $display("FAIL reset_in_ready got=%b exp=0", obs_ready);
            end
            checks++;
            if ({wr_en, wr_data, read, done, tile_loaded} !== {(COLS + DW + 3){1'b0}}) begin
                failures++;
                $display("FAIL reset_outputs got wr_en=%b wr_data=%h read=%b done=%b tile=%b exp all 0",
                         wr_en, wr_data, read, done, tile_loaded);
            end
        end
    endtask

    task automatic test_full_fill();
        logic [COLS-1:0] oh;
        for (int i = 0; i < TILE; i++) begin
            cyc(1'b1, DW'(i), '0, 1'b0, 1'b0);
            oh = COLS'(1) << (i % COLS);
            checks++;
            if (obs_ready !== 1'b1 || wr_en !== oh || wr_data !== DW'(i)) begin
                failures++;
                $display("FAIL fill_word%0d got ready=%b wr_en=%b wr_data=%h exp ready=1 wr_en=%b wr_data=%h",
                         i, obs_ready, wr_en, wr_data, oh, DW'(i));
            end
            checks++;
            if (tile_loaded !== (i == TILE - 1)) begin
                failures++;
                $display("FAIL fill_tile_loaded word=%0d got=%b exp=%b", i, tile_loaded, (i == TILE - 1));
            end
        end
        cyc(1'b1, 8'hAA, '0, 1'b0, 1'b0);
        checks++;
        if (obs_ready !== 1'b0 || wr_en !== '0 || tile_loaded !== 1'b1) begin
            failures++;
            $display("FAIL loaded_hold got ready=%b wr_en=%b tile=%b exp ready=0 wr_en=0 tile=1",
                     obs_ready, wr_en, tile_loaded);
        end
    endtask

    task automatic test_drain();
        int reads;
        bit seen;
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (read !== 1'b1 || tile_loaded !== 1'b0) begin
            failures++;
            $display("FAIL drain_first_read got read=%b tile=%b exp read=1 tile=0", read, tile_loaded);
        end
        reads = 0;
        seen  = 0;
        for (int j = 0; j < 8 && !seen; j++) begin
            checks++;
            if ({wr_en, read, done, tile_loaded} !== {exp_wr_en, exp_read, exp_done, exp_tile}) begin
                failures++;
                $display("FAIL drain_cycle%0d got=%b exp=%b", j, {wr_en, read, done, tile_loaded},
                         {exp_wr_en, exp_read, exp_done, exp_tile});
            end
            if (read) reads++;
            if (done) begin
                seen = 1;
                checks++;
                if (in_ready !== 1'b1 || tile_loaded !== 1'b0) begin
                    failures++;
                    $display("FAIL drain_done_state got ready=%b tile=%b exp ready=1 tile=0",
                             in_ready, tile_loaded);
                end
            end else begin
                cyc(1'b0, '0, '0, 1'b0, 1'b0);
            end
        end
        checks++;
        if (reads != ROWS || !seen) begin
            failures++;
            $display("FAIL drain_reads got reads=%0d done_seen=%0d exp reads=%0d done_seen=1", reads, seen, ROWS);
        end
    endtask

    task automatic test_backpressure();
        fill_words(2, 8'h10);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'h22, 4'b0100, 1'b0, 1'b0);
            checks++;
            if (obs_ready !== 1'b0 || wr_en !== '0) begin
                failures++;
                $display("FAIL stall_cycle%0d got ready=%b wr_en=%b exp ready=0 wr_en=0", i, obs_ready, wr_en);
            end
        end
        cyc(1'b1, 8'h22, '0, 1'b0, 1'b0);
        checks++;
        if (obs_ready !== 1'b1 || wr_en !== 4'b0100 || wr_data !== 8'h22) begin
            failures++;
            $display("FAIL stall_resume got ready=%b wr_en=%b wr_data=%h exp ready=1 wr_en=0100 wr_data=22",
                     obs_ready, wr_en, wr_data);
        end
        fill_words(TILE - 3, 8'h23);
        checks++;
        if (tile_loaded !== 1'b1) begin
            failures++;
            $display("FAIL stall_tile_count got tile=%b exp=1", tile_loaded);
        end
        run_drain();
    endtask

    task automatic test_ignored_start();
        int reads;
        fill_words(6, 8'h30);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (tile_loaded !== 1'b0 || read !== 1'b0 || obs_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_in_fill got tile=%b read=%b ready=%b exp tile=0 read=0 ready=1",
                     tile_loaded, read, obs_ready);
        end
        cyc(1'b1, 8'h36, '0, 1'b0, 1'b0);
        checks++;
        if (wr_en !== 4'b0100 || wr_data !== 8'h36) begin
            failures++;
            $display("FAIL start_in_fill_next got wr_en=%b wr_data=%h exp wr_en=0100 wr_data=36", wr_en, wr_data);
        end
        fill_words(TILE - 7, 8'h37);
        checks++;
        if (tile_loaded !== 1'b1) begin
            failures++;
            $display("FAIL ign_tile_loaded got=%b exp=1", tile_loaded);
        end
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        reads = read ? 1 : 0;
        for (int j = 0; j < 8; j++) begin
            cyc(1'b0, '0, '0, 1'b1, 1'b0);
            if (read) reads++;
            checks++;
            if ({read, done, tile_loaded} !== {exp_read, exp_done, exp_tile}) begin
                failures++;
                $display("FAIL start_in_drain cycle%0d got=%b exp=%b", j, {read, done, tile_loaded},
                         {exp_read, exp_done, exp_tile});
            end
        end
        checks++;
        if (reads != ROWS) begin
            failures++;
            $display("FAIL ign_read_count got=%0d exp=%0d", reads, ROWS);
        end
    endtask

    task automatic test_done_overlap();
        bit seen;
        fill_words(TILE, 8'h50);
        cyc(1'b1, 8'h77, '0, 1'b1, 1'b0);
        seen = 0;
        for (int j = 0; j < 8 && !seen; j++) begin
            if (done) seen = 1;
            else cyc(1'b1, 8'h77, '0, 1'b0, 1'b0);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL overlap_done_seen got=0 exp=1");
        end
        cyc(1'b1, 8'h78, '0, 1'b0, 1'b0);
        checks++;
        if (obs_ready !== 1'b1 || wr_en !== 4'b0001 || wr_data !== 8'h78) begin
            failures++;
            $display("FAIL overlap_fire got ready=%b wr_en=%b wr_data=%h exp ready=1 wr_en=0001 wr_data=78",
                     obs_ready, wr_en, wr_data);
        end
    endtask

    task automatic test_reset_mid_drain();
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        fill_words(TILE, 8'h60);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (read !== 1'b1) begin
            failures++;
            $display("FAIL rmd_second_read got=%b exp=1", read);
        end
        cyc(1'b0, '0, '0, 1'b0, 1'b1);
        checks++;
        if (read !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rmd_after_reset got read=%b done=%b exp read=0 done=0", read, done);
        end
        cyc(1'b1, 8'h5A, '0, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b0 || obs_ready !== 1'b1 || wr_en !== 4'b0001 || wr_data !== 8'h5A) begin
            failures++;
            $display("FAIL rmd_first_word got done=%b ready=%b wr_en=%b wr_data=%h exp done=0 ready=1 wr_en=0001 wr_data=5a",
                     done, obs_ready, wr_en, wr_data);
        end
        cyc(1'b0, '0, '0, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b0 || read !== 1'b0) begin
            failures++;
            $display("FAIL rmd_no_done got done=%b read=%b exp 0 0", done, read);
        end
    endtask

    task automatic test_random();
        logic            v;
        logic            s;
        logic            r;
        logic [COLS-1:0] cf;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 59) == 0);
            for (int b = 0; b < COLS; b++) cf[b] = ($urandom_range(0, 4) == 0);
            cyc(v, DW'($urandom), cf, s, r);
            checks++;
            if ({obs_ready, wr_en, wr_data, read, done, tile_loaded} !==
                {exp_ready, exp_wr_en, exp_wr_data, exp_read, exp_done, exp_tile}) begin
                failures++;
                $display("FAIL random_cycle%0d got ready=%b wr_en=%b wr_data=%h read=%b done=%b tile=%b exp ready=%b wr_en=%b wr_data=%h read=%b done=%b tile=%b",
                         i, obs_ready, wr_en, wr_data, read, done, tile_loaded,
                         exp_ready, exp_wr_en, exp_wr_data, exp_read, exp_done, exp_tile);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        col_full = '0;
        start    = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_full_fill();
        test_drain();
        test_backpressure();
        test_ignored_start();
        test_done_overlap();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 SHALL have parameter COLS, default sys_cols: number of systolic columns and weight FIFOs.
REQ-002 SHALL have parameter DW, default W_BITWIDTH: weight word width.
REQ-003 SHALL have parameter ROWS, default W_rows: rows per weight tile.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1: upstream weight word valid.
REQ-007 SHALL have port in_ready, output, 1: loader accepts a word this cycle.
REQ-008 SHALL have port in_data, input, DW: upstream weight word, row-major order.
REQ-009 SHALL have port col_full, input, COLS: per-column FIFO full flags.
REQ-010 SHALL have port wr_en, output, COLS: one-hot per-column FIFO write enable.
REQ-011 SHALL have port wr_data, output, DW: broadcast write data to all column FIFOs.
REQ-012 SHALL have port start, input, 1: request to stream the loaded tile into the array.
REQ-013 SHALL have port read, output, 1: read strobe to the weight buffer (column-0 valid).
REQ-014 SHALL have port tile_loaded, output, 1: a full tile is held and awaits start.
REQ-015 SHALL have port done, output, 1: one-cycle pulse after the last read strobe.

Function
REQ-016 SHALL implement states FILL, LOADED and DRAIN, and SHALL enter FILL out of reset.
REQ-017 SHALL define fire as in_valid AND in_ready.
REQ-018 SHALL drive in_ready high only in FILL and only when col_full[col_ptr] is low.
REQ-019 SHALL route each fired word to column col_ptr, where col_ptr counts 0..COLS-1 and wraps to 0.
REQ-020 SHALL increment row_cnt on each col_ptr wrap.
REQ-021 SHALL register writes with 1-cycle latency: the cycle after a fire, wr_en has exactly bit col_ptr(fire) set and wr_data equals the fired word.
REQ-022 SHALL drive wr_en to zero in every cycle that does not follow a fire.
REQ-023 SHALL, on the fire of word ROWS*COLS-1 (last column of last row), enter LOADED on the next cycle and clear col_ptr and row_cnt.
REQ-024 SHALL hold tile_loaded high throughout LOADED and low otherwise.
REQ-025 SHALL hold in_ready low in LOADED and DRAIN, with in_valid ignored.
REQ-026 SHALL, on start in LOADED, enter DRAIN on the next cycle.
REQ-027 SHALL ignore start in FILL and in DRAIN, with no queuing.
REQ-028 SHALL, in DRAIN, hold read high for exactly ROWS consecutive cycles, counted by drain_cnt from 0 to ROWS-1.
REQ-029 SHALL, on the cycle after the last read, pulse done for one cycle and enter FILL.
REQ-030 SHALL allow a new fire in the same cycle that done is high.
REQ-031 SHALL, when col_full rises mid-row, stall with col_ptr held, losing and duplicating no word.
REQ-032 SHALL size counters as col_ptr $clog2(COLS), row_cnt $clog2(ROWS+1) and drain_cnt $clog2(ROWS+1), with no overflow for COLS or ROWS of 1.

Reset
REQ-033 SHALL, while rst is high at posedge, force state FILL; col_ptr, row_cnt and drain_cnt 0; wr_en 0; wr_data 0; read 0; done 0; tile_loaded 0; in_ready 0 for the reset cycle.
REQ-034 SHALL give reset priority over all other inputs, including a fire or start in the same cycle.
REQ-035 SHALL, on reset during DRAIN, deassert read on the next edge and not emit done.

Structure
REQ-036 SHALL place the state enum typedef (wl_state_t: FILL, LOADED, DRAIN) in the shared Config package alongside sys_cols, W_BITWIDTH and W_rows.
REQ-037 SHALL be a single module with no sub-module, since counters and the FSM are inline.

Verification (COLS=4, ROWS=3)
REQ-038 SHALL verify full fill: 12 back-to-back valid words 0..11 -> wr_en one-hot sequence 1,2,4,8 repeated 3 times with wr_data 0..11 each one cycle after fire; tile_loaded high the cycle after word 11; in_ready low thereafter.
REQ-039 SHALL verify drain: start pulse in LOADED -> read high exactly 3 cycles starting 1 cycle later; done high 1 cycle after; in_ready high again with tile_loaded low.
REQ-040 SHALL verify backpressure: col_full[2]=1 for 5 cycles while col_ptr=2 -> in_ready low 5 cycles, no wr_en; word resumes into column 2 with correct data.
REQ-041 SHALL verify ignored start: start during FILL (after word 5) and during DRAIN -> no state change, read count stays exactly 3 per tile.
REQ-042 SHALL verify reset mid-drain: rst during 2nd read cycle -> read 0 next cycle, no done, next fill's first word lands in column 0 (wr_en=1).
REQ-043 SHALL verify done and fire overlap: in_valid held high across done -> word accepted in the done cycle with wr_en=1 on the following cycle.
